// File: rtl/rtc_pulsadores_cond_if.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_pulsadores_cond_if
//  Description : Front-panel button bundle. Carries the three raw push-buttons
//                towards the conditioner and the three clean edit levels back
//                to the RTC controller.
//                  btn_hora  / btn_fecha / btn_timer : raw asynchronous buttons
//                  S1 (hora) / S0 (fecha) / S2 (timer): clean exclusive levels
//                master : button source / level consumer side
//                slave  : conditioner side
//  Revision    : 1.0 - initial release
// ============================================================================
interface rtc_pulsadores_cond_if;
    logic btn_hora;
    logic btn_fecha;
    logic btn_timer;
    logic S1;
    logic S0;
    logic S2;

    modport master (
        output btn_hora, btn_fecha, btn_timer,
        input  S1, S0, S2
    );

    modport slave (
        input  btn_hora, btn_fecha, btn_timer,
        output S1, S0, S2
    );
endinterface
`default_nettype wire

// File: rtl/rtc_pulsadores_cond.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_pulsadores_cond
//  Description : Conditions the hora/fecha/timer push-buttons into the clean,
//                mutually exclusive S1/S0/S2 levels for the RTC controller.
//                Each button goes through a 2-FF synchronizer and a
//                consecutive-sample debouncer; an arbitration FSM then lets at
//                most one level through and holds it for the whole press.
//  Ports       : clk   - system clock
//                reset - synchronous, active-high reset
//                pb    - button bundle (slave): btn_* in, S0/S1/S2 out
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_pulsadores_cond #(
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 20
) (
    input  wire logic               clk,
    input  wire logic               reset,
    rtc_pulsadores_cond_if.slave    pb
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // Channel index: 0 = hora, 1 = fecha, 2 = timer
    logic [2:0] btn_raw_w;
    logic [2:0] stable_w;

    assign btn_raw_w = {pb.btn_timer, pb.btn_fecha, pb.btn_hora};

    // ------------------------------------------------------------------------
    // Per-channel synchronizer and debouncer
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < 3; g++) begin : g_chan
            logic             sync1_q;
            logic             sync2_q;
            logic             stable_q;
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q  <= 1'b0;
                    sync2_q  <= 1'b0;
                    stable_q <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    sync1_q <= btn_raw_w[g];
                    sync2_q <= sync1_q;
                    // Any run that ends before the count completes falls back
                    // into the first branch and clears the counter.
                    if (sync2_q == stable_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        stable_q <= sync2_q;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
            end

            assign stable_w[g] = stable_q;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOLD_HORA  = 3'd1,
        ST_HOLD_FECHA = 3'd2,
        ST_HOLD_TIMER = 3'd3,
        ST_WAIT_REL   = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   s0_q, s1_q, s2_q;
    logic   s0_d, s1_d, s2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // fecha > hora > timer, mirroring the controller's S0 > S1 > S2
            ST_IDLE: begin
                if (stable_w[1])      state_d = ST_HOLD_FECHA;
                else if (stable_w[0]) state_d = ST_HOLD_HORA;
                else if (stable_w[2]) state_d = ST_HOLD_TIMER;
            end
            ST_HOLD_HORA:  if (!stable_w[0]) state_d = ST_WAIT_REL;
            ST_HOLD_FECHA: if (!stable_w[1]) state_d = ST_WAIT_REL;
            ST_HOLD_TIMER: if (!stable_w[2]) state_d = ST_WAIT_REL;
            // A button still held after the active one is released must not
            // start a new edit; wait until the panel is completely released.
            ST_WAIT_REL:   if (stable_w == 3'b000) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register.
    always_comb begin
        s0_d = 1'b0;
        s1_d = 1'b0;
        s2_d = 1'b0;
        case (state_d)
            ST_HOLD_HORA:  s1_d = 1'b1;
            ST_HOLD_FECHA: s0_d = 1'b1;
            ST_HOLD_TIMER: s2_d = 1'b1;
            default: begin
                s0_d = 1'b0;
                s1_d = 1'b0;
                s2_d = 1'b0;
            end
        endcase
    end

    assign pb.S0 = s0_q;
    assign pb.S1 = s1_q;
    assign pb.S2 = s2_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_pulsadores_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_pulsadores_cond
//  Description : Directed bench for rtc_pulsadores_cond with DEB_CYCLES=4,
//                CNT_W=3 (press/release latency of 7 edges). Each segment
//                holds an input pattern for a number of edges and checks
//                {S0,S1,S2} after every one of those edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_pulsadores_cond;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    rtc_pulsadores_cond_if pb ();

    rtc_pulsadores_cond #(
        .DEB_CYCLES (4),
        .CNT_W      (3)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .pb    (pb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // btn = {hora, fecha, timer}; exp = {S0, S1, S2}
    typedef struct {
        logic       rst;
        logic [2:0] btn;
        int         n;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Apply a pattern, then check the outputs after each of the next n edges.
    task automatic seg(input string name, input logic rst, input logic [2:0] btn,
                       input int n, input logic [2:0] exp);
        logic [2:0] got;
        reset        = rst;
        pb.btn_hora  = btn[2];
        pb.btn_fecha = btn[1];
        pb.btn_timer = btn[0];
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            got = {pb.S0, pb.S1, pb.S2};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL %s edge %0d: {S0,S1,S2} got %b expected %b", name, i + 1, got, exp);
            end
        end
    endtask

    // Full release after a held level: still high for 6 edges, drops on the 7th.
    task automatic release_all(input string name, input logic [2:0] held);
        seg(name, 1'b0, 3'b000, 6, held);
        seg(name, 1'b0, 3'b000, 1, 3'b000);
        seg(name, 1'b0, 3'b000, 3, 3'b000);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset        = 1'b1;
        pb.btn_hora  = 1'b1;
        pb.btn_fecha = 1'b1;
        pb.btn_timer = 1'b1;

        // Reset with all buttons high, then fecha wins 7 edges after release
        tbl.push_back(vec_t'{1'b1, 3'b111, 3,  3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b111, 6,  3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b111, 1,  3'b100});
        tbl.push_back(vec_t'{1'b0, 3'b111, 3,  3'b100});
        tbl.push_back(vec_t'{1'b0, 3'b000, 6,  3'b100});
        tbl.push_back(vec_t'{1'b0, 3'b000, 1,  3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b000, 3,  3'b000});
        // Glitch on hora (3 cycles) is rejected, then a 20-cycle press
        tbl.push_back(vec_t'{1'b0, 3'b100, 3,  3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b000, 8,  3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b100, 6,  3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b100, 14, 3'b010});
        tbl.push_back(vec_t'{1'b0, 3'b000, 6,  3'b010});
        tbl.push_back(vec_t'{1'b0, 3'b000, 1,  3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b000, 3,  3'b000});
        // hora and fecha together: fecha has priority, S1 never rises
        tbl.push_back(vec_t'{1'b0, 3'b110, 6,  3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b110, 1,  3'b100});
        tbl.push_back(vec_t'{1'b0, 3'b110, 5,  3'b100});
        tbl.push_back(vec_t'{1'b0, 3'b000, 6,  3'b100});
        tbl.push_back(vec_t'{1'b0, 3'b000, 1,  3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b000, 3,  3'b000});

        for (int k = 0; k < tbl.size(); k++) begin
            seg($sformatf("vec%0d", k), tbl[k].rst, tbl[k].btn, tbl[k].n, tbl[k].exp);
        end

        // Exclusivity: fecha pressed while timer holds is ignored, and stays
        // ignored after timer is released until everything is released.
        seg("excl_timer_press",   1'b0, 3'b001, 6,  3'b000);
        seg("excl_timer_rise",    1'b0, 3'b001, 1,  3'b001);
        seg("excl_timer_hold",    1'b0, 3'b001, 3,  3'b001);
        seg("excl_fecha_ignored", 1'b0, 3'b011, 12, 3'b001);
        seg("excl_timer_relh",    1'b0, 3'b010, 6,  3'b001);
        seg("excl_timer_fall",    1'b0, 3'b010, 1,  3'b000);
        seg("excl_wait_rel",      1'b0, 3'b010, 8,  3'b000);
        seg("excl_fecha_rel",     1'b0, 3'b000, 10, 3'b000);
        // A fresh hora press must be accepted, proving the FSM is idle again
        seg("excl_idle_press",    1'b0, 3'b100, 6,  3'b000);
        seg("excl_idle_rise",     1'b0, 3'b100, 1,  3'b010);
        release_all("excl_idle_rel", 3'b010);

        // Reset in the middle of a hora hold
        seg("rst_mid_press",      1'b0, 3'b100, 6,  3'b000);
        seg("rst_mid_rise",       1'b0, 3'b100, 1,  3'b010);
        seg("rst_mid_hold",       1'b0, 3'b100, 2,  3'b010);
        seg("rst_mid_reset",      1'b1, 3'b100, 1,  3'b000);
        seg("rst_mid_redebounce", 1'b0, 3'b100, 6,  3'b000);
        seg("rst_mid_reassert",   1'b0, 3'b100, 1,  3'b010);
        release_all("rst_mid_rel", 3'b010);

        // Bounce train on fecha, then a steady press
        for (int b = 0; b < 5; b++) begin
            seg("bounce_high", 1'b0, 3'b010, 2, 3'b000);
            seg("bounce_low",  1'b0, 3'b000, 2, 3'b000);
        end
        seg("bounce_settle", 1'b0, 3'b010, 6, 3'b000);
        seg("bounce_rise",   1'b0, 3'b010, 1, 3'b100);
        release_all("bounce_rel", 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
